// File: rtl/be_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package be_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} be_state_e;

   localparam int unsigned DefWidth = 8;
   localparam int unsigned DefDigit = 1;

   // Width of a counter spanning n digit steps, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      if (n <= 1) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/be_digit_add.sv
// Combinational DIGIT-bit ripple of full-adder cells.
module be_digit_add #(
   parameter int unsigned DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb_in
);

   logic [DIGIT:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co       = c[DIGIT];
   assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/be_serial_adder.sv
// Digit-serial WIDTH-bit adder/subtractor with start/busy/done handshake.
// Optional signed-overflow output Ov is built when BE_SERIAL_OVF_EN is defined.
module be_serial_adder
   import be_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned DIGIT = DefDigit
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             Sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Co
`ifdef BE_SERIAL_OVF_EN
   ,
   output logic             Ov
`endif
);

   if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("be_serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
   end

   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned CW = cnt_width(N);

   be_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q, s_q;
   logic             carry_q, co_q;
   logic             load, last;

   logic [DIGIT-1:0] dsum;
   logic             dco, dmsb;
   logic [WIDTH-1:0] dsum_ext, acc_next;

   be_digit_add #(
      .DIGIT (DIGIT)
   ) u_digit_add (
      .a        (a_q[DIGIT-1:0]),
      .b        (b_q[DIGIT-1:0]),
      .ci       (carry_q),
      .s        (dsum),
      .co       (dco),
      .c_msb_in (dmsb)
   );

   // New digit enters at the MSB end; after N steps acc holds the full sum.
   assign dsum_ext = WIDTH'(dsum) << (WIDTH - DIGIT);
   assign acc_next = (acc_q >> DIGIT) | dsum_ext;

   assign load = start && (state_q != StRun);
   assign last = (state_q == StRun) && (cnt_q == CW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: if (start) state_d = StRun;
                         else       state_d = StIdle;
         StRun:          if (last)  state_d = StDone;
         default:        state_d = StIdle;
      endcase
   end

   always_comb begin
      busy = (state_q == StRun);
      done = (state_q == StDone);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         co_q    <= 1'b0;
      end else if (load) begin
         cnt_q   <= '0;
         a_q     <= A;
         b_q     <= Sub ? ~B : B;
         carry_q <= Sub ? 1'b1 : Ci;
      end else if (state_q == StRun) begin
         cnt_q   <= cnt_q + CW'(1);
         a_q     <= a_q >> DIGIT;
         b_q     <= b_q >> DIGIT;
         acc_q   <= acc_next;
         carry_q <= dco;
         if (last) begin
            s_q  <= acc_next;
            co_q <= dco;
         end
      end
   end

   assign S  = s_q;
   assign Co = co_q;

`ifdef BE_SERIAL_OVF_EN
   logic ov_q;

   // On the final step the digit MSB is bit WIDTH-1, so dmsb is the carry into it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    ov_q <= 1'b0;
      else if (last) ov_q <= dmsb ^ dco;
   end

   assign Ov = ov_q;
`else
   logic unused_dmsb;
   assign unused_dmsb = dmsb;
`endif

endmodule

// File: tb/tb_be_serial_adder.sv
// Directed bench: four WIDTH=8 instances with DIGIT = 1, 2, 4, 8 (N = 8, 4, 2, 1).
module tb_be_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] start_v;
   logic       sub, ci;
   logic [7:0] a, b;
   logic [3:0] busy_v, done_v, co_v;
   logic [7:0] s_v [4];
`ifdef BE_SERIAL_OVF_EN
   logic [3:0] ov_v;
`endif

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   be_serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .Sub(sub), .A(a), .B(b), .Ci(ci),
      .busy(busy_v[0]), .done(done_v[0]), .S(s_v[0]), .Co(co_v[0])
`ifdef BE_SERIAL_OVF_EN
      , .Ov(ov_v[0])
`endif
   );
   be_serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .Sub(sub), .A(a), .B(b), .Ci(ci),
      .busy(busy_v[1]), .done(done_v[1]), .S(s_v[1]), .Co(co_v[1])
`ifdef BE_SERIAL_OVF_EN
      , .Ov(ov_v[1])
`endif
   );
   be_serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .Sub(sub), .A(a), .B(b), .Ci(ci),
      .busy(busy_v[2]), .done(done_v[2]), .S(s_v[2]), .Co(co_v[2])
`ifdef BE_SERIAL_OVF_EN
      , .Ov(ov_v[2])
`endif
   );
   be_serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]), .Sub(sub), .A(a), .B(b), .Ci(ci),
      .busy(busy_v[3]), .done(done_v[3]), .S(s_v[3]), .Co(co_v[3])
`ifdef BE_SERIAL_OVF_EN
      , .Ov(ov_v[3])
`endif
   );

   typedef struct {
      int         k;
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic       sub;
      logic [7:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   vec_t vt [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at #1 after a posedge; returns at #1 after the edge that raised done.
   task automatic run_op(input int k, input logic [7:0] va, input logic [7:0] vb,
                         input logic vci, input logic vsub, output int cycles);
      a = va; b = vb; ci = vci; sub = vsub;
      start_v[k] = 1'b1;
      @(posedge clk); #1;
      start_v[k] = 1'b0;
      a = ~va; b = vb ^ 8'h5A; ci = ~vci; sub = ~vsub;
      check("busy_after_start", 32'(busy_v[k]), 32'd1);
      cycles = 0;
      while (!done_v[k] && cycles < 40) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   initial begin
      int cyc, pulses, lat;
      logic [7:0] got_s;
      logic got_co;

      vt[0]  = '{0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
      vt[1]  = '{1, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
      vt[2]  = '{2, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
      vt[3]  = '{2, 8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0};  // back-to-back in done
      vt[4]  = '{3, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      vt[5]  = '{0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      vt[6]  = '{1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
      vt[7]  = '{1, 8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
      vt[8]  = '{3, 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      vt[9]  = '{2, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      vt[10] = '{0, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
      vt[11] = '{3, 8'h12, 8'h34, 1'b1, 1'b1, 8'hDE, 1'b0, 1'b0};

      rst_n = 1'b0; start_v = '0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
      #3;
      for (int k = 0; k < 4; k++) begin
         check("reset_busy", 32'(busy_v[k]), 32'd0);
         check("reset_done", 32'(done_v[k]), 32'd0);
         check("reset_s", 32'(s_v[k]), 32'd0);
         check("reset_co", 32'(co_v[k]), 32'd0);
`ifdef BE_SERIAL_OVF_EN
         check("reset_ov", 32'(ov_v[k]), 32'd0);
`endif
      end
      #9 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         run_op(vt[i].k, vt[i].a, vt[i].b, vt[i].ci, vt[i].sub, cyc);
         check($sformatf("v%0d_latency", i), 32'(cyc), 32'(8 >> vt[i].k));
         check($sformatf("v%0d_busy_in_done", i), 32'(busy_v[vt[i].k]), 32'd0);
         check($sformatf("v%0d_s", i), 32'(s_v[vt[i].k]), 32'(vt[i].s));
         check($sformatf("v%0d_co", i), 32'(co_v[vt[i].k]), 32'(vt[i].co));
`ifdef BE_SERIAL_OVF_EN
         check($sformatf("v%0d_ov", i), 32'(ov_v[vt[i].k]), 32'(vt[i].ov));
`endif
      end

      // done lasts one cycle
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done_v[0]), 32'd0);

      // start re-pulsed mid-RUN on the DIGIT=1 unit must be ignored
      a = 8'h5A; b = 8'h3C; ci = 1'b0; sub = 1'b0;
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      pulses = 0; lat = 0; got_s = '0; got_co = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         if (c == 3) begin
            a = 8'hFF; b = 8'hFF; ci = 1'b1; start_v[0] = 1'b1;
         end else begin
            start_v[0] = 1'b0;
         end
         @(posedge clk); #1;
         if (done_v[0]) begin
            pulses++; lat = c; got_s = s_v[0]; got_co = co_v[0];
         end
      end
      start_v[0] = 1'b0;
      check("ignore_pulses", 32'(pulses), 32'd1);
      check("ignore_latency", 32'(lat), 32'd8);
      check("ignore_s", 32'(got_s), 32'h96);
      check("ignore_co", 32'(got_co), 32'd0);

      // asynchronous reset in the middle of an operation
      a = 8'h01; b = 8'h01; ci = 1'b0; sub = 1'b0;
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("hold_s_mid_run", 32'(s_v[0]), 32'h96);
      check("busy_mid_run", 32'(busy_v[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy_v[0]), 32'd0);
      check("abort_done", 32'(done_v[0]), 32'd0);
      check("abort_s", 32'(s_v[0]), 32'd0);
      check("abort_co", 32'(co_v[0]), 32'd0);
`ifdef BE_SERIAL_OVF_EN
      check("abort_ov", 32'(ov_v[0]), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_no_done", 32'(done_v[0]), 32'd0);
      run_op(0, 8'h01, 8'h01, 1'b0, 1'b0, cyc);
      check("post_reset_latency", 32'(cyc), 32'd8);
      check("post_reset_s", 32'(s_v[0]), 32'h02);
      check("post_reset_co", 32'(co_v[0]), 32'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/be_serial_adder.md
# be_serial_adder

Multi-cycle, digit-serial adder/subtractor that generalises the single-bit full adder to WIDTH-bit operands, processing DIGIT bits per clock through a registered carry. It sits beside the arithmetic datapath as an area-cheap alternative to a full-width ripple adder, with a start/busy/done handshake toward the controlling logic. Add and subtract are selectable per operation.

## Interface
- WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; accepted only when busy=0.
- Sub  input  1  0 = A+B+Ci, 1 = A−B (B inverted, carry-in forced 1, Ci ignored); sampled with start.
- A  input  WIDTH  operand A, sampled with start.
- B  input  WIDTH  operand B, sampled with start.
- Ci  input  1  carry-in, sampled with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- S  output  WIDTH  result, held until next completion.
- Co  output  1  carry-out (in Sub mode: 1 = no borrow).
- Ov  output  1  signed overflow; present only with BE_SERIAL_OVF_EN.

## Operation
- N = WIDTH/DIGIT digit steps per operation.
- FSM states: IDLE, RUN, DONE. Reset state IDLE.
- IDLE/DONE: start=1 → capture A, B (inverted if Sub), carry = Sub ? 1 : Ci, count=0, go RUN. start=0 → IDLE.
- RUN: each cycle adds the least-significant DIGIT bits of the A/B shift registers plus carry; sum digit shifts into the internal result register from the MSB end; carry register updated; count increments. At count = N−1 the final sum is written to S, carry-out to Co, and the FSM goes to DONE.
- DONE: lasts one cycle; done=1. Behaves as IDLE for start (back-to-back accepted).
- start while busy=1 is ignored; operands do not need to be held after the start edge.
- S/Co change only at completion; they never show partial sums.
- Arithmetic is modulo 2^WIDTH; Co is the carry out of bit WIDTH−1.
- Reset values: busy=0, done=0, S=0, Co=0, Ov=0, state IDLE, counter 0.
- rst_n asserted mid-operation: operation aborted, all outputs return to reset values immediately (asynchronously), no done pulse.

## Timing
- Start edge t (start=1, busy=0): busy=1 from after edge t through edge t+N.
- S, Co, Ov valid after edge t+N; done=1 for exactly the cycle between edges t+N and t+N+1; busy=0 in that cycle.
- Latency start-edge to done = N cycles; throughput one operation per N cycles with back-to-back start during done.
- DIGIT=WIDTH degenerates to N=1: done one cycle after start.

## Configuration
- BE_SERIAL_OVF_EN defined: Ov port present; Ov = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1, registered with S; reset 0.
- Not defined: Ov port and its logic absent; all other behaviour identical.

## Structure
- Shared package be_pkg: FSM state typedef (IDLE, RUN, DONE), default WIDTH/DIGIT constants, and a function returning counter width $clog2(N) (minimum 1).
- One sub-module: be_digit_add, combinational DIGIT-bit ripple of full-adder cells (inputs a, b, ci; outputs s, co, and c_msb_in for overflow).
- Top holds FSM, counter, operand/result shift registers and carry register; parameter legality checked at elaboration.

## Test plan
- WIDTH=8, DIGIT=1, A=8'h5A, B=8'h3C, Ci=0, Sub=0 → after 8 cycles done pulse, S=8'h96, Co=0; Ov=1 with macro.
- WIDTH=8, DIGIT=2, A=8'hFF, B=8'h01, Ci=1 → done after 4 cycles, S=8'h01, Co=1, Ov=0.
- WIDTH=8, DIGIT=4, Sub=1, A=8'h10, B=8'h20 → done after 2 cycles, S=8'hF0, Co=0 (borrow); second op A=8'h20, B=8'h10 started in done cycle → S=8'h10, Co=1, 2 cycles later.
- start pulsed again mid-RUN with different operands → ignored; result matches first operands, single done pulse.
- rst_n low at RUN cycle 3 → busy, done, S, Co, Ov all 0 immediately; after release, new start completes normally.
- Randomised sweep over WIDTH∈{4,8,16}, DIGIT divisors, Sub, Ci → S/Co/Ov match reference model; S stable between done pulses.
